// File: rtl/la_ioremap.sv
// la_ioremap: runtime-programmable pad<->core channel remapper.
// Each pad has a (sel, en) table entry. A table write holds the target pad at
// high-Z for GUARD cycles before the new route commits, so the pad never
// glitches between the old and the new channel.
module la_ioremap #(
    parameter  int N     = 8,
    parameter  int GUARD = 4,
    localparam int SELW  = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [SELW-1:0] cfg_pad,
    input  logic [SELW-1:0] cfg_sel,
    input  logic            cfg_en,
    output logic            cfg_err,
    output logic            busy,
    input  logic [N-1:0]    core_out,
    input  logic [N-1:0]    core_oe,
    output logic [N-1:0]    core_in,
    output logic [N-1:0]    pad_out,
    output logic [N-1:0]    pad_oe,
    input  logic [N-1:0]    pad_in
);
    localparam int CW = $clog2(GUARD + 1);

    typedef enum logic {S_IDLE, S_GUARD} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SELW-1:0]        pend_pad_q, pend_pad_d;
    logic [SELW-1:0]        pend_sel_q, pend_sel_d;
    logic                   pend_en_q, pend_en_d;
    logic [N-1:0][SELW-1:0] sel_q, sel_d;
    logic [N-1:0]           en_q, en_d;
    logic                   err_evt_q, err_evt_d;
    logic                   cfg_err_q, cfg_err_d;
    logic [N-1:0]           pad_out_q, pad_out_d;
    logic [N-1:0]           pad_oe_q, pad_oe_d;
    logic [N-1:0]           core_in_q, core_in_d;
    logic [N-1:0]           mask;
    logic                   hs;
    logic                   req_ok;

    // The config port is closed while resetting so nothing is accepted then.
    assign cfg_ready = (state_q == S_IDLE) && !rst;
    assign busy      = (state_q == S_GUARD) && !rst;
    assign hs        = cfg_valid && cfg_ready;
    assign req_ok    = (32'(cfg_pad) < 32'(N)) && (32'(cfg_sel) < 32'(N));

    // Config FSM: accept/reject requests, count down the guard, commit the entry.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_pad_d = pend_pad_q;
        pend_sel_d = pend_sel_q;
        pend_en_d  = pend_en_q;
        sel_d      = sel_q;
        en_d       = en_q;
        err_evt_d  = 1'b0;
        // Error is flagged one stage later so it lines up with the other registered outputs.
        cfg_err_d  = err_evt_q;
        case (state_q)
            S_IDLE: begin
                if (hs) begin
                    if (req_ok) begin
                        pend_pad_d = cfg_pad;
                        pend_sel_d = cfg_sel;
                        pend_en_d  = cfg_en;
                        cnt_d      = CW'(GUARD - 1);
                        state_d    = S_GUARD;
                    end else begin
                        err_evt_d = 1'b1;
                    end
                end
            end
            S_GUARD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    sel_d[pend_pad_q] = pend_sel_q;
                    en_d[pend_pad_q]  = pend_en_q;
                    state_d           = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Only the pad being rewritten is parked during the guard window.
    always_comb begin
        mask = '0;
        if (state_q == S_GUARD) mask[pend_pad_q] = 1'b1;
    end

    // Routing: pads pick their channel; each channel takes the lowest live pad.
    always_comb begin
        pad_out_d = '0;
        pad_oe_d  = '0;
        core_in_d = '0;
        for (int p = 0; p < N; p++) begin
            pad_out_d[p] = (en_q[p] && !mask[p]) ? core_out[sel_q[p]] : 1'b0;
            pad_oe_d[p]  = (en_q[p] && !mask[p]) ? core_oe[sel_q[p]]  : 1'b0;
        end
        for (int c = 0; c < N; c++) begin
            // Walk downward so the lowest matching pad is the last writer.
            for (int p = N - 1; p >= 0; p--) begin
                if (en_q[p] && !mask[p] && (sel_q[p] == SELW'(c))) core_in_d[c] = pad_in[p];
            end
        end
    end

    // State and output registers; reset restores the identity alias.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            pend_pad_q <= '0;
            pend_sel_q <= '0;
            pend_en_q  <= 1'b0;
            en_q       <= '1;
            for (int p = 0; p < N; p++) sel_q[p] <= SELW'(p);
            err_evt_q  <= 1'b0;
            cfg_err_q  <= 1'b0;
            pad_out_q  <= '0;
            pad_oe_q   <= '0;
            core_in_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_pad_q <= pend_pad_d;
            pend_sel_q <= pend_sel_d;
            pend_en_q  <= pend_en_d;
            sel_q      <= sel_d;
            en_q       <= en_d;
            err_evt_q  <= err_evt_d;
            cfg_err_q  <= cfg_err_d;
            pad_out_q  <= pad_out_d;
            pad_oe_q   <= pad_oe_d;
            core_in_q  <= core_in_d;
        end
    end

    assign cfg_err = cfg_err_q;
    assign pad_out = pad_out_q;
    assign pad_oe  = pad_oe_q;
    assign core_in = core_in_q;

endmodule

// File: tb/tb_la_ioremap.sv
// Bench for la_ioremap: an N=8/GUARD=4 instance for routing and guard timing,
// and an N=6/GUARD=2 instance for out-of-range requests.
module tb_la_ioremap;
    localparam int N     = 8;
    localparam int GUARD = 4;
    localparam int N6    = 6;
    localparam int G6    = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         cfg_valid, cfg_en, cfg_ready, cfg_err, busy;
    logic [2:0]   cfg_pad, cfg_sel;
    logic [N-1:0] core_out, core_oe, core_in, pad_out, pad_oe, pad_in;

    logic          b_cfg_valid, b_cfg_en, b_cfg_ready, b_cfg_err, b_busy;
    logic [2:0]    b_cfg_pad, b_cfg_sel;
    logic [N6-1:0] b_core_out, b_core_oe, b_core_in, b_pad_out, b_pad_oe, b_pad_in;

    la_ioremap #(.N(N), .GUARD(GUARD)) u8 (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_pad(cfg_pad),
        .cfg_sel(cfg_sel), .cfg_en(cfg_en), .cfg_err(cfg_err), .busy(busy),
        .core_out(core_out), .core_oe(core_oe), .core_in(core_in),
        .pad_out(pad_out), .pad_oe(pad_oe), .pad_in(pad_in)
    );

    la_ioremap #(.N(N6), .GUARD(G6)) u6 (
        .clk(clk), .rst(rst),
        .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready), .cfg_pad(b_cfg_pad),
        .cfg_sel(b_cfg_sel), .cfg_en(b_cfg_en), .cfg_err(b_cfg_err), .busy(b_busy),
        .core_out(b_core_out), .core_oe(b_core_oe), .core_in(b_core_in),
        .pad_out(b_pad_out), .pad_oe(b_pad_oe), .pad_in(b_pad_in)
    );

    typedef struct {
        string      name;
        logic [7:0] o;
        logic [7:0] oe;
        logic [7:0] i;
    } exp_t;

    typedef struct {
        logic [7:0] co;
        logic [7:0] coe;
        logic [7:0] pin;
        logic [7:0] eo;
        logic [7:0] eoe;
        logic [7:0] ei;
    } vec_t;

    exp_t sbq[$];
    vec_t vt[4];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected pad/core outputs for the edge about to be taken.
    task automatic expect_o(input string name, input logic [7:0] o, input logic [7:0] oe,
                            input logic [7:0] i);
        exp_t e;
        e.name = name;
        e.o    = o;
        e.oe   = oe;
        e.i    = i;
        sbq.push_back(e);
    endtask

    // One clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({e.name, ".pad_out"}, 32'(pad_out), 32'(e.o));
            chk({e.name, ".pad_oe"},  32'(pad_oe),  32'(e.oe));
            chk({e.name, ".core_in"}, 32'(core_in), 32'(e.i));
        end
    endtask

    task automatic drive(input logic [7:0] co, input logic [7:0] coe, input logic [7:0] pin);
        core_out = co;
        core_oe  = coe;
        pad_in   = pin;
    endtask

    task automatic wait_ready(input string name);
        int w = 0;
        while (!cfg_ready && w < 40) begin
            tick();
            w++;
        end
        chk(name, 32'(cfg_ready), 32'd1);
    endtask

    task automatic do_cfg(input logic [2:0] p, input logic [2:0] s, input logic e);
        wait_ready("cfg.pre_ready");
        cfg_valid = 1'b1;
        cfg_pad   = p;
        cfg_sel   = s;
        cfg_en    = e;
        tick();
        cfg_valid = 1'b0;
        chk("cfg.busy_after_hs", 32'(busy), 32'd1);
        wait_ready("cfg.post_ready");
    endtask

    int   t0, t1, cyc, low;
    logic hs_pend;

    initial begin
        vt[0] = '{8'hA5, 8'hFF, 8'h3C, 8'hA5, 8'hFF, 8'h3C};
        vt[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[2] = '{8'hFF, 8'h0F, 8'hC3, 8'hFF, 8'h0F, 8'hC3};
        vt[3] = '{8'h5A, 8'h81, 8'h7E, 8'h5A, 8'h81, 8'h7E};

        rst = 1'b1;
        cfg_valid = 1'b0; cfg_pad = '0; cfg_sel = '0; cfg_en = 1'b0;
        b_cfg_valid = 1'b0; b_cfg_pad = '0; b_cfg_sel = '0; b_cfg_en = 1'b0;
        b_core_out = 6'h2D; b_core_oe = 6'h3F; b_pad_in = 6'h15;
        drive(8'hA5, 8'hFF, 8'h3C);

        // Reset: outputs held at zero, config port closed.
        tick();
        expect_o("reset", 8'h00, 8'h00, 8'h00);
        tick();
        chk("reset.cfg_ready", 32'(cfg_ready), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.cfg_err", 32'(cfg_err), 32'd0);
        chk("reset.b_pad_oe", 32'(b_pad_oe), 32'd0);
        rst = 1'b0;
        expect_o("identity.first", 8'hA5, 8'hFF, 8'h3C);
        tick();
        chk("identity.cfg_ready", 32'(cfg_ready), 32'd1);

        // Identity routing under several patterns.
        for (int v = 0; v < 4; v++) begin
            drive(vt[v].co, vt[v].coe, vt[v].pin);
            expect_o($sformatf("vec%0d", v), vt[v].eo, vt[v].eoe, vt[v].ei);
            tick();
        end

        // Remap pad 2 -> channel 5 and watch the guard window edge by edge.
        drive(8'h20, 8'hFF, 8'h04);
        expect_o("remap.pre", 8'h20, 8'hFF, 8'h04);
        tick();
        cfg_valid = 1'b1; cfg_pad = 3'd2; cfg_sel = 3'd5; cfg_en = 1'b1;
        chk("remap.ready_before", 32'(cfg_ready), 32'd1);
        expect_o("remap.k", 8'h20, 8'hFF, 8'h04);
        tick();
        cfg_valid = 1'b0;
        chk("remap.busy_k", 32'(busy), 32'd1);
        chk("remap.ready_k", 32'(cfg_ready), 32'd0);
        for (int i = 1; i <= GUARD; i++) begin
            expect_o($sformatf("remap.guard%0d", i), 8'h20, 8'hFB, 8'h00);
            tick();
            chk($sformatf("remap.busy%0d", i), 32'(busy), 32'(i < GUARD));
            chk($sformatf("remap.ready%0d", i), 32'(cfg_ready), 32'(i == GUARD));
        end
        expect_o("remap.commit", 8'h24, 8'hFF, 8'h20);
        tick();

        // Fan-out and lowest-pad priority on channel 0.
        do_cfg(3'd0, 3'd0, 1'b0);
        do_cfg(3'd1, 3'd0, 1'b1);
        do_cfg(3'd6, 3'd0, 1'b1);
        drive(8'h01, 8'h01, 8'hC0);
        expect_o("fanout.a", 8'h42, 8'h42, 8'h80);
        tick();
        drive(8'hFF, 8'h00, 8'h02);
        expect_o("fanout.b", 8'hFE, 8'h00, 8'h01);
        tick();
        do_cfg(3'd1, 3'd0, 1'b0);
        drive(8'h01, 8'h01, 8'hC0);
        expect_o("fanout.pad1_off", 8'h40, 8'h40, 8'h81);
        tick();

        // Reset in the middle of a guard window discards the pending route.
        cfg_valid = 1'b1; cfg_pad = 3'd3; cfg_sel = 3'd0; cfg_en = 1'b1;
        expect_o("rmg.k", 8'h40, 8'h40, 8'h81);
        tick();
        cfg_valid = 1'b0;
        expect_o("rmg.k1", 8'h40, 8'h40, 8'h81);
        tick();
        chk("rmg.busy_k1", 32'(busy), 32'd1);
        rst = 1'b1;
        expect_o("rmg.in_reset", 8'h00, 8'h00, 8'h00);
        tick();
        chk("rmg.busy_rst", 32'(busy), 32'd0);
        chk("rmg.ready_rst", 32'(cfg_ready), 32'd0);
        rst = 1'b0;
        expect_o("rmg.identity", 8'h01, 8'h01, 8'hC0);
        tick();
        chk("rmg.busy_after", 32'(busy), 32'd0);
        drive(vt[3].co, vt[3].coe, vt[3].pin);
        expect_o("rmg.identity2", vt[3].eo, vt[3].eoe, vt[3].ei);
        tick();

        // Held cfg_valid with two queued writes; first rewrites pad 4 with its current value.
        t0 = -1; t1 = -1; cyc = 0; low = 0;
        drive(8'h00, 8'hFF, 8'h00);
        cfg_valid = 1'b1; cfg_pad = 3'd4; cfg_sel = 3'd4; cfg_en = 1'b1;
        for (int k = 0; k < 30 && t1 < 0; k++) begin
            hs_pend = cfg_valid && cfg_ready;
            tick();
            cyc++;
            if (!pad_oe[4]) low++;
            if (hs_pend) begin
                if (t0 < 0) begin
                    t0 = cyc;
                    cfg_pad = 3'd5;
                    cfg_sel = 3'd5;
                end else begin
                    t1 = cyc;
                end
            end
        end
        cfg_valid = 1'b0;
        chk("b2b.interval", 32'(t1 - t0), 32'(GUARD + 1));
        chk("b2b.same_value_guard", 32'(low), 32'(GUARD));
        wait_ready("b2b.done");
        drive(vt[2].co, vt[2].coe, vt[2].pin);
        expect_o("b2b.identity", vt[2].eo, vt[2].eoe, vt[2].ei);
        tick();

        // N=6: out-of-range pad and out-of-range channel are both rejected.
        chk("n6.identity_out", 32'(b_pad_out), 32'h2D);
        chk("n6.identity_in", 32'(b_core_in), 32'h15);
        b_cfg_valid = 1'b1; b_cfg_pad = 3'd7; b_cfg_sel = 3'd0; b_cfg_en = 1'b1;
        chk("n6.ready_before", 32'(b_cfg_ready), 32'd1);
        tick();
        b_cfg_valid = 1'b0;
        chk("n6.bad_pad.err_k", 32'(b_cfg_err), 32'd0);
        chk("n6.bad_pad.busy", 32'(b_busy), 32'd0);
        chk("n6.bad_pad.ready", 32'(b_cfg_ready), 32'd1);
        tick();
        chk("n6.bad_pad.err_k1", 32'(b_cfg_err), 32'd1);
        chk("n6.bad_pad.busy_k1", 32'(b_busy), 32'd0);
        tick();
        chk("n6.bad_pad.err_k2", 32'(b_cfg_err), 32'd0);
        b_cfg_valid = 1'b1; b_cfg_pad = 3'd1; b_cfg_sel = 3'd6;
        tick();
        b_cfg_valid = 1'b0;
        tick();
        chk("n6.bad_sel.err", 32'(b_cfg_err), 32'd1);
        tick();
        chk("n6.bad_sel.err_clear", 32'(b_cfg_err), 32'd0);
        chk("n6.unchanged_out", 32'(b_pad_out), 32'h2D);
        chk("n6.unchanged_in", 32'(b_core_in), 32'h15);

        // N=6 valid remap pad 0 -> channel 1 with a two-cycle guard.
        b_cfg_valid = 1'b1; b_cfg_pad = 3'd0; b_cfg_sel = 3'd1; b_cfg_en = 1'b1;
        tick();
        b_cfg_valid = 1'b0;
        chk("n6.remap.busy_k", 32'(b_busy), 32'd1);
        tick();
        chk("n6.remap.oe_k1", 32'(b_pad_oe), 32'h3E);
        chk("n6.remap.busy_k1", 32'(b_busy), 32'd1);
        tick();
        chk("n6.remap.oe_k2", 32'(b_pad_oe), 32'h3E);
        chk("n6.remap.ready_k2", 32'(b_cfg_ready), 32'd1);
        tick();
        chk("n6.remap.out", 32'(b_pad_out), 32'h2C);
        chk("n6.remap.oe", 32'(b_pad_oe), 32'h3F);
        chk("n6.remap.in", 32'(b_core_in), 32'h16);
        chk("n6.remap.err", 32'(b_cfg_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
